uart_rx_os: RTL
===============

# uart_rx_os

Parametrised, oversampling UART receiver: the next-generation serial front end for the board's RS-232 link. It samples `rx` on an external baud tick at OS× the bit rate, validates the start bit, and receives 5..DATA_W data bits, optional even/odd parity and 1 or 2 stop bits. It reports parity, framing and overrun errors separately, and buffers received words in a DEPTH-entry FIFO with a valid/ready pop port and RTS flow control.

## Interface
- DATA_W, 8: maximum data bits per frame and width of `data_out`; range 5..8.
- OS, 16: baud ticks per bit; even, ≥8.
- DEPTH, 4: receive FIFO entries; power of 2, ≥2.

- clk  in  1  system clock.
- rst  in  1  reset; one clock, asynchronous and active-high.
- baud_tick  in  1  one-clk pulse, OS per bit period.
- rx  in  1  serial line, idle high, asynchronous.
- amount_bits  in  4  data bits per frame; <5 is treated as 5, >DATA_W as DATA_W.
- parity_en  in  1  frame carries a parity bit.
- even  in  1  1 = even parity, 0 = odd parity.
- two_stop  in  1  1 = two stop bits, 0 = one.
- data_out  out  DATA_W  FIFO head, LSB = first bit received, unused MSBs zero.
- valid  out  1  FIFO not empty.
- ready_in  in  1  consumer pops the head when `valid && ready_in`.
- rts  out  1  1 = sender may transmit; `fifo_count <= DEPTH-2`.
- frame_err  out  1  one-clk pulse: a stop bit was sampled 0.
- parity_err  out  1  one-clk pulse: parity mismatch.
- overrun  out  1  one-clk pulse: good word dropped because FIFO full.

## Operation
- `rx` passes a 2-flop synchroniser; both flops reset to 1. All sampling uses the synchronised value `rxs`.
- `amount_bits`, `parity_en`, `even` and `two_stop` are latched at start-bit detection. Changes mid-frame have no effect.
- A tick counter `tc` (0..OS-1) advances only on `baud_tick`. The sample point is `tc == OS/2`.
- States:
  - IDLE: on a tick with `rxs==0`, set `tc=0`, go to START.
  - START: at the sample point, if `rxs==1` (glitch), go to IDLE with no error. Otherwise go to DATA.
  - DATA: sample one bit per bit period at the sample point, shifting LSB-first. After `n` bits, go to PARITY if enabled, else STOP.
  - PARITY: sample the parity bit. An error exists if the XOR of the data bits and the parity bit ≠ (even ? 0 : 1).
  - STOP: sample 1 or 2 stop bits. Any 0 flags a framing error.
  - After the last stop sample:
    - Framing error: pulse `frame_err`, drop the word, go to WAIT_HIGH.
    - Else parity error: pulse `parity_err`, drop the word, go to IDLE.
    - Else FIFO full: pulse `overrun`, drop the word, go to IDLE.
    - Else: push the word and go to IDLE.
  - WAIT_HIGH: stay until `rxs==1`, then go to IDLE. A break (line held low) yields exactly one `frame_err` pulse.
- FIFO behaviour:
  - A pop while empty is ignored.
  - Push and pop in the same clk are both performed. When full, the push sees the pre-pop count and is dropped as overrun.
  - Pointers wrap modulo DEPTH.
- Reset mid-frame aborts the frame and empties the FIFO. No error pulse is generated.

## Timing
- Reset values: `data_out=0`, `valid=0`, `rts=1`, `frame_err=0`, `parity_err=0`, `overrun=0`, state IDLE, FIFO empty.
- Start detection latency is 2 clk for the synchroniser, plus the first tick seeing `rxs==0`.
- The push, or the error pulse, is registered on the clk of the final stop-bit sample. `valid` and the new `data_out` appear on the next clk.
- `rts` is registered from the FIFO count and updates 1 clk after a push or pop.
- Error pulses are exactly 1 clk wide. The receiver reaches IDLE by mid-stop-bit, so back-to-back frames with no idle gap are received.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each start, data, parity and stop bit value is the 2-of-3 majority of samples at `tc` = OS/2-1, OS/2 and OS/2+1.
  - The decision is made at OS/2+1.
- `UART_RX_MAJORITY_EN` undefined:
  - Each bit is a single sample at `tc == OS/2`.
  - The majority logic is not synthesised.

## Test plan
- 8N1, OS=16, byte 0xA5 -> `valid` rises 1 clk after the stop sample; `data_out=0xA5`; no error pulses.
- 7E2, byte 0x35, correct parity bit 0 -> `data_out=0x35` (MSB 0). Same frame with parity bit 1 -> one `parity_err` pulse, FIFO unchanged.
- Stop bit driven 0, then `rx` held low for 3 frame times -> exactly one `frame_err` pulse; no push; IDLE only after `rx` returns high.
- Start glitch `rx` low for 4 ticks -> no frame, no error, state IDLE.
- `ready_in=0`, DEPTH=4, send 5 good bytes 0x01..0x05:
  - `rts` falls after byte 3.
  - Byte 5 gives one `overrun` pulse.
  - Pops then return 0x01..0x04 in order.
- Assert `rst` mid-data-bit, then send 0x3C -> no stale word; FIFO empty after reset; `data_out=0x3C` received correctly.

Source files
------------

// File: rtl/uart_rx_os_if.sv
// Receive-side pop port of uart_rx_os: FIFO head, valid/ready handshake and RTS.
interface uart_rx_os_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              ready_in;
    logic              rts;

    modport master (output data_out, valid, rts, input ready_in);
    modport slave  (input data_out, valid, rts, output ready_in);
endinterface

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with parity/framing/overrun flags and a receive FIFO.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around the mid-bit tick.
module uart_rx_os #(
    parameter int DATA_W = 8,
    parameter int OS     = 16,
    parameter int DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         baud_tick,
    input  logic         rx,
    input  logic [3:0]   amount_bits,
    input  logic         parity_en,
    input  logic         even,
    input  logic         two_stop,
    uart_rx_os_if.master rd,
    output logic         frame_err,
    output logic         parity_err,
    output logic         overrun
);
    localparam int TW = $clog2(OS);
    localparam int BW = $clog2(DATA_W);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [TW-1:0] TC_MID = TW'(OS / 2);
    localparam logic [TW-1:0] TC_MAX = TW'(OS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;

    state_t            state_q, state_d;
    logic              rx_meta_q, rxs_q;
    logic [TW-1:0]     tc_q, tc_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [3:0]        nbits_q, nbits_d;
    logic              par_en_q, par_en_d, even_q, even_d, two_stop_q, two_stop_d;
    logic              stop_cnt_q, stop_cnt_d, fe_q, fe_d, pe_q, pe_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rts_q, rts_d;
    logic              frame_err_q, frame_err_d, parity_err_q, parity_err_d, overrun_q, overrun_d;
    logic              samp, bit_val, push, pop, stop_fe;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_q, maj_d;

    always_comb begin
        maj_d = maj_q;
        if (baud_tick && (tc_q == TC_MID - TW'(1) || tc_q == TC_MID)) maj_d = {maj_q[0], rxs_q};
        samp    = baud_tick && (tc_q == TC_MID + TW'(1));
        bit_val = (maj_q[1] & maj_q[0]) | (maj_q[1] & rxs_q) | (maj_q[0] & rxs_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) maj_q <= 2'b11;
        else     maj_q <= maj_d;
    end
`else
    assign samp    = baud_tick && (tc_q == TC_MID);
    assign bit_val = rxs_q;
`endif

    always_comb begin
        state_d      = state_q;
        tc_d         = tc_q;
        bit_cnt_d    = bit_cnt_q;
        nbits_d      = nbits_q;
        par_en_d     = par_en_q;
        even_d       = even_q;
        two_stop_d   = two_stop_q;
        stop_cnt_d   = stop_cnt_q;
        fe_d         = fe_q;
        pe_d         = pe_q;
        shreg_d      = shreg_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;
        push         = 1'b0;
        stop_fe      = fe_q | ~bit_val;
        if (baud_tick) tc_d = (tc_q == TC_MAX) ? '0 : tc_q + TW'(1);

        case (state_q)
            S_IDLE: if (baud_tick && !rxs_q) begin
                state_d    = S_START;
                tc_d       = '0;
                nbits_d    = (amount_bits < 4'd5) ? 4'd5 :
                             (amount_bits > 4'(DATA_W)) ? 4'(DATA_W) : amount_bits;
                par_en_d   = parity_en;
                even_d     = even;
                two_stop_d = two_stop;
            end
            S_START: if (samp) begin
                if (bit_val) begin
                    state_d = S_IDLE;
                end else begin
                    state_d    = S_DATA;
                    bit_cnt_d  = '0;
                    shreg_d    = '0;
                    pe_d       = 1'b0;
                    fe_d       = 1'b0;
                    stop_cnt_d = 1'b0;
                end
            end
            S_DATA: if (samp) begin
                // Bits land at their final position so short frames keep the MSBs zero.
                shreg_d[bit_cnt_q] = bit_val;
                bit_cnt_d          = bit_cnt_q + BW'(1);
                if (4'(bit_cnt_q) == nbits_q - 4'd1) state_d = par_en_q ? S_PARITY : S_STOP;
            end
            S_PARITY: if (samp) begin
                pe_d    = ((^shreg_q) ^ bit_val) != ~even_q;
                state_d = S_STOP;
            end
            S_STOP: if (samp) begin
                if (two_stop_q && !stop_cnt_q) begin
                    stop_cnt_d = 1'b1;
                    fe_d       = stop_fe;
                end else if (stop_fe) begin
                    frame_err_d = 1'b1;
                    state_d     = S_WAIT_HIGH;
                end else begin
                    state_d = S_IDLE;
                    if (pe_q)                         parity_err_d = 1'b1;
                    else if (count_q == CW'(DEPTH))   overrun_d    = 1'b1;
                    else                              push         = 1'b1;
                end
            end
            S_WAIT_HIGH: if (rxs_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop    = (count_q != '0) && rd.ready_in;
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q] = shreg_q;
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop) rptr_d = rptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
        rts_d   = count_q <= CW'(DEPTH - 2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            state_q      <= S_IDLE;
            tc_q         <= '0;
            bit_cnt_q    <= '0;
            nbits_q      <= 4'(DATA_W);
            par_en_q     <= 1'b0;
            even_q       <= 1'b0;
            two_stop_q   <= 1'b0;
            stop_cnt_q   <= 1'b0;
            fe_q         <= 1'b0;
            pe_q         <= 1'b0;
            shreg_q      <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            rts_q        <= 1'b1;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rxs_q        <= rx_meta_q;
            state_q      <= state_d;
            tc_q         <= tc_d;
            bit_cnt_q    <= bit_cnt_d;
            nbits_q      <= nbits_d;
            par_en_q     <= par_en_d;
            even_q       <= even_d;
            two_stop_q   <= two_stop_d;
            stop_cnt_q   <= stop_cnt_d;
            fe_q         <= fe_d;
            pe_q         <= pe_d;
            shreg_q      <= shreg_d;
            mem_q        <= mem_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            rts_q        <= rts_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rd.data_out = mem_q[rptr_q];
    assign rd.valid    = count_q != '0;
    assign rd.rts      = rts_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun     = overrun_q;
endmodule
